// File: rtl/pri_enc_pkg.sv
// Shared types and constants for the round-robin / fixed-priority encoder.
package pri_enc_pkg;

  // Output register state: EMPTY means no grant is held, FULL means idx is valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/pri_enc_find.sv
// Combinational wrapped search: scan downward from a start index, wrapping
// from 0 to N-1; the first set request wins.
module pri_enc_find
  import pri_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] win_idx,
  output logic         any
);

  int top_pos;
  int pos;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop, so no
    // path through this block leaves a value unassigned and no latch is inferred.
    win_idx = '0;
    any     = 1'b0;
    top_pos = N - 1;
    pos     = 0;

    // Fixed priority is simply the wrapped search started at the top index.
    // An out-of-range start cannot occur, but is clamped for non-power-of-two N.
    if (mode == MODE_RR && int'(start) < N) begin
      top_pos = int'(start);
    end

    for (int k = 0; k < N; k++) begin
      pos = top_pos - k;
      if (pos < 0) begin
        pos = pos + N;
      end
      if (!any && req[pos]) begin
        any     = 1'b1;
        win_idx = W'(pos);
      end
    end
  end

endmodule

// File: rtl/pri_enc_rr.sv
// Registered priority encoder with valid/ready output and a round-robin
// pointer that advances past each accepted grant.
module pri_enc_rr
  import pri_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx
);

  state_t         state;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_next;
  logic [W-1:0]   start;
  logic [W-1:0]   win_idx;
  logic           any;
  logic           handshake;
  logic           capture;

  assign handshake = (state == FULL) && out_ready;
  assign capture   = en && any;
  assign ptr_next  = (idx == '0) ? W'(N - 1) : idx - 1'b1;

  // A back-to-back capture must already see the pointer moved past the grant
  // being accepted, otherwise round-robin would repeat the same winner.
  assign start = handshake ? ptr_next : ptr;

  pri_enc_find #(
    .N(N),
    .W(W)
  ) u_find (
    .req    (req),
    .start  (start),
    .mode   (mode),
    .win_idx(win_idx),
    .any    (any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      idx       <= '0;
      ptr       <= W'(N - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (capture) begin
            idx       <= win_idx;
            out_valid <= 1'b1;
            state     <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            ptr <= ptr_next;
            if (capture) begin
              idx <= win_idx;
            end else begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end
        end
      endcase
    end
  end

  // Design invariants: idx stays in range, and a stalled grant is held stable.
  a_idx_range : assert property (@(posedge clk) disable iff (!rst_n)
    idx <= W'(N - 1));

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(idx)));

  a_valid_state : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid == (state == FULL));

endmodule

// File: tb/tb_pri_enc_rr.sv
// Self-checking bench for pri_enc_rr: directed scenarios plus randomized
// traffic compared each cycle against a behavioural reference model.
module tb_pri_enc_rr;
  import pri_enc_pkg::*;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] req = '0;
  logic         out_valid;
  logic [W-1:0] idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;

  always #5 clk = ~clk;

  pri_enc_rr #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .req      (req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .idx      (idx)
  );

  // Winner by plain rules: fixed = highest set bit; round-robin = first set
  // bit scanning start..0, then N-1..start+1.
  function automatic int ref_winner(logic [N-1:0] r, logic m, int start);
    if (m == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int i = start; i >= 0; i--) if (r[i]) return i;
      for (int i = N - 1; i > start; i--) if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (!rst_n) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = N - 1;
    end else if (!m_valid || out_ready) begin
      if (m_valid) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
      if (en && req != '0) begin
        m_valid = 1'b1;
        m_idx   = ref_winner(req, mode, m_ptr);
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic cycle(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, " valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, " idx"}, 32'(idx), 32'(m_idx));
  endtask

  task automatic expect_out(string tag, bit v, int i);
    check({tag, " valid(lit)"}, 32'(out_valid), 32'(v));
    check({tag, " idx(lit)"}, 32'(idx), 32'(i));
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    cycle("reset");
    cycle("reset");
    expect_out("reset", 1'b0, 0);

    // Fixed priority, single capture
    rst_n = 1'b1; mode = MODE_FIXED; en = 1'b1; req = 8'b0010_0110; out_ready = 1'b1;
    cycle("fixed_first");
    expect_out("fixed_first", 1'b1, 5);
    en = 1'b0;
    cycle("drain");
    expect_out("drain", 1'b0, 5);

    // Stall holds idx while req changes; handshake then captures new req
    en = 1'b1; req = 8'h81; out_ready = 1'b0;
    cycle("stall_cap");
    expect_out("stall_cap", 1'b1, 7);
    req = 8'h02;
    for (int i = 0; i < 3; i++) begin
      cycle("stall_hold");
      expect_out("stall_hold", 1'b1, 7);
    end
    out_ready = 1'b1;
    cycle("stall_release");
    expect_out("stall_release", 1'b1, 1);

    // Round-robin over all requests
    rst_n = 1'b0;
    cycle("rr_reset");
    rst_n = 1'b1; mode = MODE_RR; en = 1'b1; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle("rr_all");
      expect_out("rr_all", 1'b1, (i == 8) ? 7 : 7 - i);
    end

    // Round-robin alternation between the two end bits
    rst_n = 1'b0;
    cycle("rr2_reset");
    rst_n = 1'b1; req = 8'b1000_0001;
    for (int i = 0; i < 4; i++) begin
      cycle("rr_alt");
      expect_out("rr_alt", 1'b1, (i % 2 == 0) ? 7 : 0);
    end

    // en=0 blocks capture; empty request with handshake drains to EMPTY
    rst_n = 1'b0;
    cycle("en_reset");
    rst_n = 1'b1; en = 1'b0; req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cycle("en_off");
      expect_out("en_off", 1'b0, 0);
    end
    en = 1'b1; req = 8'h04; out_ready = 1'b0;
    cycle("cap_two");
    expect_out("cap_two", 1'b1, 2);
    req = '0; out_ready = 1'b1;
    cycle("empty_req");
    expect_out("empty_req", 1'b0, 2);

    // Reset wins over a pending grant and a simultaneous handshake
    mode = MODE_FIXED; req = 8'h40; out_ready = 1'b0;
    cycle("pre_rst");
    expect_out("pre_rst", 1'b1, 6);
    rst_n = 1'b0; out_ready = 1'b1; req = 8'hFF;
    cycle("rst_win");
    expect_out("rst_win", 1'b0, 0);
    rst_n = 1'b1; mode = MODE_RR;
    cycle("post_rst");
    expect_out("post_rst", 1'b1, 7);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = N'($urandom) & N'($urandom) & N'($urandom);
        default: req = N'($urandom);
      endcase
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pri_enc_rr.md
PRI_ENC_RR -- requirements
Module: pri_enc_rr

Interface
REQ-001 SHALL have parameter N, default 8: number of request inputs, 2..64.
REQ-002 SHALL have parameter W, default $clog2(N): index width, derived, not overridden.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1: capture enable; when 0, no new request vector is captured.
REQ-006 SHALL have port mode  input  1: search mode; 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 SHALL have port req  input  N: request vector.
REQ-008 SHALL have port out_valid  output  1: idx holds a valid encoded grant.
REQ-009 SHALL have port out_ready  input  1: consumer accepts idx this cycle.
REQ-010 SHALL have port idx  output  W: encoded index of the winning request.

Function
REQ-011 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 SHALL use "capture" to mean: on a clock edge with en=1 and req!=0, load idx with the winner, set out_valid=1, and enter FULL.
REQ-013 In EMPTY, SHALL capture when en=1 and req!=0; otherwise remain EMPTY with idx unchanged.
REQ-014 In FULL with out_ready=0, SHALL hold idx and out_valid stable regardless of req, en or mode.
REQ-015 In FULL with out_ready=1 (handshake), SHALL capture if en=1 and req!=0 (back-to-back, stay FULL); otherwise go to EMPTY.
REQ-016 SHALL give a latency of exactly one cycle from req sampled to out_valid/idx; no combinational path from req to outputs.
REQ-017 In mode 0, SHALL select the highest set index of req.
REQ-018 In mode 1, SHALL search downward starting at pointer ptr (W bits) and wrap from 0 to N-1; the first set bit wins.
REQ-019 SHALL update ptr only on a handshake: ptr <= (idx==0) ? N-1 : idx-1.
REQ-020 SHALL apply a mode change only at the next capture; a held idx is unaffected.
REQ-021 SHALL never output high-impedance; en=0 drives idx to hold, not Z.
REQ-022 SHALL ignore req bits at or above N (none exist); for N not a power of two, idx SHALL never exceed N-1.

Reset
REQ-023 With rst_n=0 at a clock edge, SHALL set state=EMPTY, out_valid=0, idx=0 and ptr=N-1.
REQ-024 SHALL let reset win over a simultaneous capture or handshake; a pending FULL grant is discarded.
REQ-025 SHALL capture no request on the first edge after reset deasserts unless en=1 and req!=0 at that edge.

Structure
REQ-026 SHALL place the state enum (EMPTY, FULL) and the mode constants (MODE_FIXED=0, MODE_RR=1) in the shared package pri_enc_pkg.
REQ-027 SHALL contain one combinational sub-module, pri_enc_find (params N, W; inputs req, start, mode; outputs win_idx, any), which performs the wrapped search; the top holds the FSM, idx, and ptr registers.
REQ-028 SHALL keep RTL within 120-400 lines including the sub-module.

Verification (N=8)
REQ-029 Reset then mode=0, en=1, req=8'b0010_0110, out_ready=1 -> next cycle out_valid=1, idx=5.
REQ-030 mode=0, req=8'h81, out_ready=0 for 3 cycles, req then changes to 8'h02 -> idx stays 7 and out_valid=1 until ready; after handshake idx=1.
REQ-031 mode=1, req=8'hFF constant, out_ready=1 -> idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
REQ-032 mode=1, req=8'b1000_0001, ptr=7 after reset, out_ready=1 -> idx alternates 7,0,7,0.
REQ-033 en=0 with req=8'hFF -> out_valid stays 0 and idx holds; en=1 with req=0 in FULL plus handshake -> EMPTY next cycle.
REQ-034 rst_n=0 asserted while FULL with idx=6 -> next edge out_valid=0, idx=0; mode=1 first capture with req=8'hFF gives idx=7.
